instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream neighbour of the instruction ROM in the single-cycle MIPS datapath.
- Owns the program counter and drives the ROM's word address.
- Captures the combinational ROM word into an output register and presents it to decode with a valid/ready handshake.
- Handles redirects (branch/jump), stalls, halt and address faults.

Parameters:
- ADDR_WIDTH, 32: width of the PC and the ROM address.
- DATA_WIDTH, 32: instruction width.
- RESET_PC, 32'h0000_0000: byte address loaded into the PC on reset.
- IMEM_WORDS, 1024: number of valid ROM words; a fetch at word index >= IMEM_WORDS is a fault.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_rom_addr  out  ADDR_WIDTH  ROM word index = {2'b00, pc[ADDR_WIDTH-1:2]}; combinational from the PC.
- i_rom_data  in  DATA_WIDTH  ROM word at o_rom_addr, same cycle.
- i_redirect_valid  in  1  load a new PC this cycle.
- i_redirect_pc  in  ADDR_WIDTH  redirect target, byte address.
- i_halt  in  1  stop fetching; level-sensitive.
- i_instr_ready  in  1  decode accepts o_instr this cycle.
- o_instr_valid  out  1  o_instr/o_pc hold a fetched instruction.
- o_instr  out  DATA_WIDTH  fetched instruction.
- o_pc  out  ADDR_WIDTH  byte address of o_instr.
- o_pc_plus4  out  ADDR_WIDTH  o_pc+4, combinational, modulo 2^ADDR_WIDTH.
- o_fault  out  1  sticky; set on out-of-range fetch or misaligned redirect.

Behaviour:
Reset:
- Asynchronous assert: PC=RESET_PC, state=BOOT, o_instr_valid=0, o_instr=0, o_pc=0, o_fault=0.
- Release is used synchronously.

States:
- BOOT: one idle cycle with no fetch, then go to RUN.
- RUN: fetches.
- HALTED: no fetch.
- FAULT: no fetch; terminal until reset.

Load condition:
- load = (state==RUN) && (!o_instr_valid || i_instr_ready).

Fetch in RUN, priority order:
1. Redirect:
   - o_instr_valid <= 0; the word at the old PC is dropped, even if it was being accepted.
   - PC <= i_redirect_pc.
   - If i_redirect_pc[1:0] != 0: o_fault <= 1, go to FAULT, PC unchanged.
2. Out of range: word index >= IMEM_WORDS and load:
   - o_fault <= 1, go to FAULT, no load.
   - Any valid output entry drains normally.
3. Halt: if i_halt, go to HALTED, no load. Any valid entry drains.
4. Load:
   - o_instr <= i_rom_data, o_pc <= PC, o_instr_valid <= 1, PC <= PC+4 (wraps modulo 2^ADDR_WIDTH).
5. Stall: no load, no redirect, valid entry not accepted:
   - PC, o_instr and o_pc all hold.
   - o_instr_valid stays 1; o_instr is stable while valid && !ready.

Handshake and timing:
- Transfer occurs when o_instr_valid && i_instr_ready. If no new load occurs that cycle, o_instr_valid <= 0.
- Latency: an instruction at PC is visible on o_instr one cycle after its fetch cycle.
- Throughput: one instruction per cycle with ready held high.

Other states:
- HALTED:
  - i_redirect_valid loads PC (with the alignment check) and returns to RUN.
  - Deassertion of i_halt with no redirect returns to RUN at the held PC.
- BOOT: a redirect is applied, then the block moves to RUN.
- FAULT: ignores redirect and halt; o_fault stays 1; the output entry still drains.

Reset mid-operation:
- Immediately clears valid and fault and returns to BOOT.
- No partial transfer is reported.

Decomposition:
- Shared package (fetch_pkg):
  - State enum: BOOT, RUN, HALTED, FAULT.
  - NOP constant 32'h0.
  - Default RESET_PC and IMEM_WORDS constants, reused by the ROM instance.
- Sub-module fetch_out_reg: the valid/instr/pc output register with its load/accept/flush logic. Keeps the handshake independently testable.
- The PC register and state machine live in instr_fetch.

Test Plan:
- Reset, then ready=1 and ROM words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000:
  - BOOT cycle: valid=0.
  - From the next edge: o_pc = 0, 4, 8, 12 on consecutive cycles with the matching o_instr.
  - o_rom_addr = 0, 1, 2, 3.
- Backpressure: ready=0 for 3 cycles while valid at o_pc=4:
  - o_instr/o_pc stay stable and PC stays at 8.
  - When ready=1, o_pc=8 follows the next cycle.
- Redirect to 0x40 while valid at o_pc=8, ready=0:
  - Next cycle valid=0; following cycle o_pc=0x40.
  - The word at 8 is never transferred.
- Misaligned redirect to 0x42:
  - o_fault=1, state FAULT, no further valid after the current entry drains.
  - Ignored by subsequent redirects.
- IMEM_WORDS=4, run sequentially: the fetch at 0x10 sets o_fault; the last transfer is o_pc=0xC.
- i_halt pulse for 5 cycles mid-stream: no new o_pc during the halt; the next fetch resumes at the held PC with no skip or duplicate.
- Reset mid-stream with valid=1: all outputs clear asynchronously; after release the first o_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage of the single-cycle MIPS datapath.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP                = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int          DEFAULT_IMEM_WORDS = 1024;

endpackage

// File: rtl/fetch_out_reg.sv
// Output register between fetch and decode: holds one instruction and its PC under a valid/ready handshake.
module fetch_out_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    // A flush wins over a load so a redirect never lets the stale word through.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_instr <= DATA_WIDTH'(NOP);
            o_pc    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_instr <= i_data;
            o_pc    <= i_pc;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and hands words to decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    input  logic                  i_halt,
    input  logic                  i_instr_ready,
    output logic                  o_instr_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic                  o_fault
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  can_load;
    logic                  do_load;
    logic                  flush;

    assign o_rom_addr   = {2'b00, pc[ADDR_WIDTH-1:2]};
    assign o_pc_plus4   = o_pc + ADDR_WIDTH'(4);
    assign out_of_range = o_rom_addr >= ADDR_WIDTH'(IMEM_WORDS);
    assign misaligned   = i_redirect_pc[1:0] != 2'b00;
    assign can_load     = (state == RUN) && (!o_instr_valid || i_instr_ready);
    assign do_load      = can_load && !i_redirect_valid && !out_of_range && !i_halt;
    // Any accepted redirect drops the held word, even one being accepted this cycle.
    assign flush        = i_redirect_valid && (state != FAULT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc      <= RESET_PC;
            state   <= BOOT;
            o_fault <= 1'b0;
        end else begin
            case (state)
                BOOT, HALTED: begin
                    if (i_redirect_valid) begin
                        if (misaligned) begin
                            o_fault <= 1'b1;
                            state   <= FAULT;
                        end else begin
                            pc    <= i_redirect_pc;
                            state <= RUN;
                        end
                    end else if (state == BOOT || !i_halt) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (i_redirect_valid) begin
                        if (misaligned) begin
                            o_fault <= 1'b1;
                            state   <= FAULT;
                        end else begin
                            pc <= i_redirect_pc;
                        end
                    end else if (out_of_range && can_load) begin
                        o_fault <= 1'b1;
                        state   <= FAULT;
                    end else if (i_halt) begin
                        state <= HALTED;
                    end else if (can_load) begin
                        pc <= pc + ADDR_WIDTH'(4);
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    fetch_out_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (do_load),
        .i_flush (flush),
        .i_ready (i_instr_ready),
        .i_data  (i_rom_data),
        .i_pc    (pc),
        .o_valid (o_instr_valid),
        .o_instr (o_instr),
        .o_pc    (o_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a full-size instance for the main sequence and a 4-word instance for the range fault.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic [31:0] rom_addr, rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        ready = 1'b1;
    logic        instr_valid, fault;
    logic [31:0] instr, pc, pc_plus4;

    logic        s_rst_n = 1'b1;
    logic [31:0] s_rom_addr, s_rom_data;
    logic        s_instr_valid, s_fault;
    logic [31:0] s_instr, s_pc, s_pc_plus4;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        case (idx)
            32'd0:   rom_word = 32'h2008_0001;
            32'd1:   rom_word = 32'h2009_0002;
            32'd2:   rom_word = 32'h0109_5020;
            32'd3:   rom_word = 32'h0000_0000;
            default: rom_word = 32'hA000_0000 | idx;
        endcase
    endfunction

    assign rom_data   = rom_word(rom_addr);
    assign s_rom_data = rom_word(s_rom_addr);

    instr_fetch dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_rom_addr       (rom_addr),
        .i_rom_data       (rom_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_halt           (halt),
        .i_instr_ready    (ready),
        .o_instr_valid    (instr_valid),
        .o_instr          (instr),
        .o_pc             (pc),
        .o_pc_plus4       (pc_plus4),
        .o_fault          (fault)
    );

    instr_fetch #(.IMEM_WORDS(4)) dut_small (
        .i_clk            (clk),
        .i_rst_n          (s_rst_n),
        .o_rom_addr       (s_rom_addr),
        .i_rom_data       (s_rom_data),
        .i_redirect_valid (1'b0),
        .i_redirect_pc    (32'h0),
        .i_halt           (1'b0),
        .i_instr_ready    (1'b1),
        .o_instr_valid    (s_instr_valid),
        .o_instr          (s_instr),
        .o_pc             (s_pc),
        .o_pc_plus4       (s_pc_plus4),
        .o_fault          (s_fault)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_entry(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check_output({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
        check_output({tag, ".pc"}, pc, exp_pc);
        check_output({tag, ".instr"}, instr, exp_instr);
    endtask

    task automatic apply_stimulus(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        ready          = rdy;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] instr_fetch directed sequence");
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        rst_n   = 1'b0;
        s_rst_n = 1'b0;
        #2;
        check_output("rst.valid", {31'b0, instr_valid}, 32'd0);
        check_output("rst.instr", instr, 32'h0);
        check_output("rst.pc", pc, 32'h0);
        check_output("rst.fault", {31'b0, fault}, 32'd0);
        check_output("rst.rom_addr", rom_addr, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check_output("boot.valid", {31'b0, instr_valid}, 32'd0);
        check_output("boot.rom_addr", rom_addr, 32'h0);

        step(1);
        check_entry("seq0", 32'h0, 32'h2008_0001);
        check_output("seq0.rom_addr", rom_addr, 32'h1);
        step(1);
        check_entry("seq1", 32'h4, 32'h2009_0002);
        check_output("seq1.rom_addr", rom_addr, 32'h2);
        step(1);
        check_entry("seq2", 32'h8, 32'h0109_5020);
        check_output("seq2.rom_addr", rom_addr, 32'h3);
        step(1);
        check_entry("seq3", 32'hC, 32'h0000_0000);
        check_output("seq3.pc_plus4", pc_plus4, 32'h10);

        // Restart at 0 so the backpressure case sees o_pc=4 with PC at 8.
        apply_stimulus(1'b1, 32'h0, 1'b0, 1'b1);
        step(1);
        check_output("restart.valid", {31'b0, instr_valid}, 32'd0);
        check_output("restart.rom_addr", rom_addr, 32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(1);
        check_entry("restart0", 32'h0, 32'h2008_0001);
        step(1);
        check_entry("restart1", 32'h4, 32'h2009_0002);

        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_entry("stall", 32'h4, 32'h2009_0002);
            check_output("stall.rom_addr", rom_addr, 32'h2);
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(1);
        check_entry("unstall", 32'h8, 32'h0109_5020);

        apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0);
        step(1);
        check_output("redir.valid", {31'b0, instr_valid}, 32'd0);
        check_output("redir.rom_addr", rom_addr, 32'h10);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(1);
        check_entry("redir.target", 32'h40, 32'hA000_0010);

        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_output("halt.valid", {31'b0, instr_valid}, 32'd0);
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(1);
        check_output("unhalt.valid", {31'b0, instr_valid}, 32'd0);
        step(1);
        check_entry("resume", 32'h44, 32'hA000_0011);

        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst.valid", {31'b0, instr_valid}, 32'd0);
        check_output("midrst.instr", instr, 32'h0);
        check_output("midrst.pc", pc, 32'h0);
        check_output("midrst.rom_addr", rom_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check_output("midrst.boot", {31'b0, instr_valid}, 32'd0);
        step(1);
        check_entry("midrst.first", 32'h0, 32'h2008_0001);
        check_output("midrst.fault", {31'b0, fault}, 32'd0);

        apply_stimulus(1'b1, 32'h42, 1'b0, 1'b0);
        step(1);
        check_output("misal.fault", {31'b0, fault}, 32'd1);
        check_output("misal.valid", {31'b0, instr_valid}, 32'd0);
        check_output("misal.rom_addr", rom_addr, 32'h1);
        apply_stimulus(1'b1, 32'h80, 1'b0, 1'b1);
        step(1);
        check_output("fault.redir.fault", {31'b0, fault}, 32'd1);
        check_output("fault.redir.rom_addr", rom_addr, 32'h1);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
        step(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step(2);
        check_output("fault.hold.valid", {31'b0, instr_valid}, 32'd0);
        check_output("fault.hold.fault", {31'b0, fault}, 32'd1);

        @(negedge clk);
        s_rst_n = 1'b1;
        step(1);
        check_output("small.boot", {31'b0, s_instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_output("small.valid", {31'b0, s_instr_valid}, 32'd1);
            check_output("small.pc", s_pc, 32'(i * 4));
            check_output("small.instr", s_instr, rom_word(32'(i)));
            check_output("small.nofault", {31'b0, s_fault}, 32'd0);
        end
        step(1);
        check_output("small.oob.fault", {31'b0, s_fault}, 32'd1);
        check_output("small.oob.valid", {31'b0, s_instr_valid}, 32'd0);
        check_output("small.oob.lastpc", s_pc, 32'hC);
        step(1);
        check_output("small.oob.hold", {31'b0, s_instr_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
